// File: rtl/frame_replay_checker_if.sv
// Framed-word input and plaintext output channels of the replay checker.
// Latency: none, pure wiring bundle.
// Backpressure: valid/ready on both channels; the slave side is the checker.
interface frame_replay_checker_if #(
  parameter int FRAMED_TOTAL_WIDTH = 512,
  parameter int MSG_WIDTH          = 488,
  parameter int FRAMER_CNTR_WIDTH  = 16
);
  logic                          valid_in;
  logic                          ready_out;
  logic [FRAMED_TOTAL_WIDTH-1:0] framed_data_in;
  logic                          valid_out;
  logic                          ready_in;
  logic [MSG_WIDTH-1:0]          plaintext_data_out;
  logic [FRAMER_CNTR_WIDTH-1:0]  cntr_out;

  modport slave (
    input  valid_in, framed_data_in, ready_in,
    output ready_out, valid_out, plaintext_data_out, cntr_out
  );

  modport master (
    output valid_in, framed_data_in, ready_in,
    input  ready_out, valid_out, plaintext_data_out, cntr_out
  );
endinterface

// File: rtl/frame_replay_checker.sv
// Verifies the auth tag of decrypted frames, drops replayed/stale counters via a sliding window.
// Latency: 1 cycle from input transfer to valid_out; full throughput of one frame per cycle.
// Backpressure: ready_out = !valid_out || ready_in; dropped frames are consumed silently.
module frame_replay_checker #(
  parameter int                           FRAMED_TOTAL_WIDTH = 512,
  parameter int                           MSG_WIDTH          = 488,
  parameter int                           FRAMER_CNTR_WIDTH  = 16,
  parameter int                           FRAMER_AUTH_WIDTH  = 8,
  parameter int                           WINDOW_SIZE        = 32,
  parameter logic [FRAMER_AUTH_WIDTH-1:0] AUTH_SEED          = 8'h5A,
  parameter bit                           CHECK_AUTH         = 1'b1,
  parameter int                           STAT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_replay_checker_if.slave bus,
  output logic                  drop_auth,
  output logic                  drop_replay,
  output logic [STAT_WIDTH-1:0] accept_cnt,
  output logic [STAT_WIDTH-1:0] auth_err_cnt,
  output logic [STAT_WIDTH-1:0] replay_err_cnt
);

  localparam int FOLD_WIDTH = MSG_WIDTH + FRAMER_CNTR_WIDTH;
  localparam int NUM_SLICES = FOLD_WIDTH / FRAMER_AUTH_WIDTH;
  localparam int WIDX_WIDTH = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam logic [WINDOW_SIZE-1:0]         WIN_ONE   = WINDOW_SIZE'(1);
  localparam logic [FRAMER_CNTR_WIDTH:0]     WIN_LIMIT = (FRAMER_CNTR_WIDTH+1)'(WINDOW_SIZE);

  // Field layout and window range are structural; reject bad combinations at elaboration.
  generate
    if (FOLD_WIDTH % FRAMER_AUTH_WIDTH != 0) begin : g_bad_fold
      $error("payload+counter width must be a multiple of the auth width");
    end
    if (FRAMED_TOTAL_WIDTH != FOLD_WIDTH + FRAMER_AUTH_WIDTH) begin : g_bad_total
      $error("framed width must equal payload+counter+auth widths");
    end
    if (WINDOW_SIZE < 1 || WINDOW_SIZE > (1 << (FRAMER_CNTR_WIDTH-1))) begin : g_bad_window
      $error("window size out of range for the counter width");
    end
  endgenerate

  typedef enum logic [1:0] {
    CLS_FRESH,
    CLS_AHEAD,
    CLS_LATE_OK,
    CLS_REPLAY
  } replay_cls_t;

  // Replay state: newest accepted counter plus a bitmap of the counters just behind it.
  logic [FRAMER_CNTR_WIDTH-1:0] top_cntr;
  logic [WINDOW_SIZE-1:0]       win;
  logic                         seen;

  // Output register.
  logic                         out_vld;
  logic [MSG_WIDTH-1:0]         out_dat;
  logic [FRAMER_CNTR_WIDTH-1:0] out_cntr;

  // Decoded view of the incoming word.
  logic [MSG_WIDTH-1:0]         in_payload;
  logic [FRAMER_CNTR_WIDTH-1:0] in_cntr;
  logic [FRAMER_AUTH_WIDTH-1:0] in_tag;
  logic [FOLD_WIDTH-1:0]        fold_body;
  logic [FRAMER_AUTH_WIDTH-1:0] exp_tag;
  logic                         auth_ok;

  logic [FRAMER_CNTR_WIDTH-1:0] dist_ahead;
  logic [FRAMER_CNTR_WIDTH-1:0] dist_back;
  logic                         ahead_in_win;
  logic                         back_in_win;
  logic                         back_bit;
  logic [WINDOW_SIZE-1:0]       win_shifted;
  replay_cls_t                  cls;

  logic                         xfer;
  logic                         accept;
  logic                         ready_int;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

  // Slice the framed word and fold payload+counter into the expected tag.
  always_comb begin
    in_payload = bus.framed_data_in[FRAMED_TOTAL_WIDTH-1 -: MSG_WIDTH];
    in_cntr    = bus.framed_data_in[FRAMER_AUTH_WIDTH +: FRAMER_CNTR_WIDTH];
    in_tag     = bus.framed_data_in[FRAMER_AUTH_WIDTH-1:0];
    fold_body  = bus.framed_data_in[FRAMED_TOTAL_WIDTH-1:FRAMER_AUTH_WIDTH];
    exp_tag    = AUTH_SEED;
    for (int i = 0; i < NUM_SLICES; i++) begin
      exp_tag = exp_tag ^ fold_body[i*FRAMER_AUTH_WIDTH +: FRAMER_AUTH_WIDTH];
    end
    auth_ok = !CHECK_AUTH || (in_tag == exp_tag);
  end

  // Classify the incoming counter against the window (modular arithmetic handles wrap).
  always_comb begin
    dist_ahead   = in_cntr - top_cntr;
    dist_back    = top_cntr - in_cntr;
    ahead_in_win = {1'b0, dist_ahead} < WIN_LIMIT;
    back_in_win  = {1'b0, dist_back} < WIN_LIMIT;
    back_bit     = back_in_win ? win[dist_back[WIDX_WIDTH-1:0]] : 1'b1;
    win_shifted  = ahead_in_win ? ((win << dist_ahead) | WIN_ONE) : WIN_ONE;
    if (!seen) begin
      cls = CLS_FRESH;
    end else if (dist_ahead != '0 && !dist_ahead[FRAMER_CNTR_WIDTH-1]) begin
      cls = CLS_AHEAD;
    end else if (!back_bit) begin
      cls = CLS_LATE_OK;
    end else begin
      cls = CLS_REPLAY;
    end
  end

  // Handshake: downstream ready passes straight through when the output register is full.
  always_comb begin
    ready_int = !out_vld || bus.ready_in;
    xfer      = bus.valid_in && ready_int;
    accept    = xfer && auth_ok && (cls != CLS_REPLAY);
  end

  assign bus.ready_out          = ready_int;
  assign bus.valid_out          = out_vld;
  assign bus.plaintext_data_out = out_dat;
  assign bus.cntr_out           = out_cntr;

  // Replay window update, output register, drop pulses and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_cntr       <= '0;
      win            <= '0;
      seen           <= 1'b0;
      out_vld        <= 1'b0;
      out_dat        <= '0;
      out_cntr       <= '0;
      drop_auth      <= 1'b0;
      drop_replay    <= 1'b0;
      accept_cnt     <= '0;
      auth_err_cnt   <= '0;
      replay_err_cnt <= '0;
    end else begin
      drop_auth   <= xfer && !auth_ok;
      drop_replay <= xfer && auth_ok && (cls == CLS_REPLAY);

      if (xfer && !auth_ok) begin
        auth_err_cnt <= sat_inc(auth_err_cnt);
      end
      if (xfer && auth_ok && (cls == CLS_REPLAY)) begin
        replay_err_cnt <= sat_inc(replay_err_cnt);
      end

      if (accept) begin
        unique case (cls)
          CLS_FRESH: begin
            top_cntr <= in_cntr;
            win      <= WIN_ONE;
            seen     <= 1'b1;
          end
          CLS_AHEAD: begin
            top_cntr <= in_cntr;
            win      <= win_shifted;
          end
          CLS_LATE_OK: begin
            win[dist_back[WIDX_WIDTH-1:0]] <= 1'b1;
          end
          default: begin
          end
        endcase
        out_vld    <= 1'b1;
        out_dat    <= in_payload;
        out_cntr   <= in_cntr;
        accept_cnt <= sat_inc(accept_cnt);
      end else if (bus.ready_in) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_replay_checker.sv
// Directed bench for frame_replay_checker: window classification, auth drops, stalls, reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: ready_in driven directly to exercise stall and full-throughput cases.
module tb_frame_replay_checker;

  localparam int TOTAL = 512;
  localparam int MSGW  = 488;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic reset;
  logic drop_auth, drop_replay;
  logic [15:0] accept_cnt, auth_err_cnt, replay_err_cnt;

  int tests = 0;
  int fails = 0;

  frame_replay_checker_if #(.FRAMED_TOTAL_WIDTH(TOTAL), .MSG_WIDTH(MSGW), .FRAMER_CNTR_WIDTH(CW)) bus ();

  frame_replay_checker dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .drop_auth      (drop_auth),
    .drop_replay    (drop_replay),
    .accept_cnt     (accept_cnt),
    .auth_err_cnt   (auth_err_cnt),
    .replay_err_cnt (replay_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [MSGW-1:0] pay(input logic [15:0] c);
    return MSGW'({c, ~c, c ^ 16'h5A5A, 32'hC0DE_0000 | 32'(c)});
  endfunction

  function automatic logic [7:0] calc_tag(input logic [15:0] c);
    logic [MSGW+CW-1:0] body;
    logic [7:0] t;
    body = {pay(c), c};
    t = 8'h5A;
    for (int i = 0; i < (MSGW+CW)/8; i++) t = t ^ body[i*8 +: 8];
    return t;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [7:0] flip);
    bus.valid_in       = v;
    bus.framed_data_in = {pay(c), c, calc_tag(c) ^ flip};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one frame for a single edge and check the result as an accept.
  task automatic send_ok(input logic [15:0] c, input logic [15:0] exp_acc, input string nm);
    drive(1'b1, c, 8'h00);
    tick();
    check({nm, "_vld"}, 512'(bus.valid_out), 512'(1));
    check({nm, "_cntr"}, 512'(bus.cntr_out), 512'(c));
    check({nm, "_data"}, 512'(bus.plaintext_data_out), 512'(pay(c)));
    check({nm, "_drop"}, 512'({drop_auth, drop_replay}), 512'(0));
    check({nm, "_acc"}, 512'(accept_cnt), 512'(exp_acc));
  endtask

  // Present one frame for a single edge and check it is dropped as a replay.
  task automatic send_replay(input logic [15:0] c, input logic [15:0] exp_rep, input string nm);
    drive(1'b1, c, 8'h00);
    tick();
    check({nm, "_vld"}, 512'(bus.valid_out), 512'(0));
    check({nm, "_drops"}, 512'({drop_auth, drop_replay}), 512'(2'b01));
    check({nm, "_rep"}, 512'(replay_err_cnt), 512'(exp_rep));
  endtask

  initial begin
    reset       = 1'b1;
    bus.ready_in = 1'b1;
    drive(1'b1, 16'd99, 8'h00);
    tick();
    tick();
    check("rst_vld", 512'(bus.valid_out), 512'(0));
    check("rst_rdy", 512'(bus.ready_out), 512'(1));
    check("rst_cntr", 512'(bus.cntr_out), 512'(0));
    check("rst_stats", 512'({accept_cnt, auth_err_cnt, replay_err_cnt}), 512'(0));
    check("rst_drops", 512'({drop_auth, drop_replay}), 512'(0));
    reset = 1'b0;
    drive(1'b0, 16'd0, 8'h00);
    tick();
    check("post_rst_acc", 512'(accept_cnt), 512'(0));

    // In-order frames, back to back.
    send_ok(16'd1, 16'd1, "c1");
    send_ok(16'd2, 16'd2, "c2");
    send_ok(16'd3, 16'd3, "c3");

    // Duplicate of 2, then 4 still accepted and pulse gone.
    send_replay(16'd2, 16'd1, "dup2");
    send_ok(16'd4, 16'd4, "c4");

    // Bad tag on 5, then good 5.
    drive(1'b1, 16'd5, 8'h01);
    tick();
    check("auth5_vld", 512'(bus.valid_out), 512'(0));
    check("auth5_drops", 512'({drop_auth, drop_replay}), 512'(2'b10));
    check("auth5_cnt", 512'(auth_err_cnt), 512'(1));
    send_ok(16'd5, 16'd5, "c5");

    // Jump ahead beyond window, late frame at b=30, too-old frame at b=32.
    send_ok(16'd40, 16'd6, "c40");
    send_ok(16'd10, 16'd7, "late10");
    send_replay(16'd8, 16'd2, "old8");

    // Walk up to 0xFFFF, wrap to 1, then check the wrapped window.
    send_ok(16'h7000, 16'd8, "c7000");
    send_ok(16'hE000, 16'd9, "cE000");
    send_ok(16'hFFFF, 16'd10, "cFFFF");
    send_ok(16'h0001, 16'd11, "wrap1");
    send_replay(16'hFFFF, 16'd3, "repFFFF");
    send_ok(16'h0000, 16'd12, "late0");
    send_replay(16'h0001, 16'd4, "top1");
    check("stats_auth", 512'(auth_err_cnt), 512'(1));

    // Stall: first frame lands, second waits while ready_in is low.
    drive(1'b0, 16'd0, 8'h00);
    tick();
    check("idle_vld", 512'(bus.valid_out), 512'(0));
    bus.ready_in = 1'b0;
    drive(1'b1, 16'd2, 8'h00);
    tick();
    check("stall_first_cntr", 512'(bus.cntr_out), 512'(2));
    drive(1'b1, 16'd3, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rdy", 512'(bus.ready_out), 512'(0));
      check("stall_vld", 512'(bus.valid_out), 512'(1));
      check("stall_data", 512'(bus.plaintext_data_out), 512'(pay(16'd2)));
    end
    check("stall_acc", 512'(accept_cnt), 512'(13));
    bus.ready_in = 1'b1;
    #1;
    check("unstall_rdy", 512'(bus.ready_out), 512'(1));
    send_ok(16'd3, 16'd14, "thru3");
    send_ok(16'd4, 16'd15, "thru4");
    send_ok(16'd5, 16'd16, "thru5");

    // Reset while a frame is held.
    bus.ready_in = 1'b0;
    drive(1'b1, 16'd6, 8'h00);
    tick();
    check("hold_cntr", 512'(bus.cntr_out), 512'(5));
    check("hold_rdy", 512'(bus.ready_out), 512'(0));
    reset = 1'b1;
    tick();
    check("midrst_vld", 512'(bus.valid_out), 512'(0));
    check("midrst_rdy", 512'(bus.ready_out), 512'(1));
    check("midrst_data", 512'({bus.plaintext_data_out, bus.cntr_out}), 512'(0));
    check("midrst_stats", 512'({accept_cnt, auth_err_cnt, replay_err_cnt}), 512'(0));
    reset = 1'b0;
    bus.ready_in = 1'b1;
    // Counter 3 would be a replay against the old window; after reset it is fresh.
    send_ok(16'd3, 16'd1, "fresh3");
    check("fresh3_rep", 512'(replay_err_cnt), 512'(0));
    drive(1'b0, 16'd0, 8'h00);
    tick();
    check("end_vld", 512'(bus.valid_out), 512'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_replay_checker.md
Name: frame_replay_checker

Overview:
- Receiver-side post-decryption checker. Sits between the ChaCha decrypt stage and the plaintext output of receiver_top.
- Takes a decrypted framed word laid out as {payload, counter, auth}. It verifies the auth tag, rejects replayed or stale counters using a parametrised sliding window, and forwards the payload of good frames downstream.
- It generalises the fixed single-counter framer check with a configurable window depth, field widths and drop statistics.

Parameters:
- FRAMED_TOTAL_WIDTH, 512: width of the framed input word.
- MSG_WIDTH, 488: payload width; occupies bits [FRAMED_TOTAL_WIDTH-1 : CNTR+AUTH].
- FRAMER_CNTR_WIDTH, 16: sequence counter field, bits [CNTR+AUTH-1 : AUTH].
- FRAMER_AUTH_WIDTH, 8: auth tag field, bits [AUTH-1:0].
- WINDOW_SIZE, 32: replay window depth in frames. Range 1..2^(CNTR-1).
- AUTH_SEED, 8'h5A: constant XORed into the auth fold.
- CHECK_AUTH, 1: 0 disables auth checking, so every tag passes.
- STAT_WIDTH, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  framed word valid.
- ready_out  out  1  block can accept framed word.
- framed_data_in  in  FRAMED_TOTAL_WIDTH  decrypted framed word.
- valid_out  out  1  plaintext valid.
- ready_in  in  1  downstream accepts plaintext.
- plaintext_data_out  out  MSG_WIDTH  payload of accepted frame.
- cntr_out  out  FRAMER_CNTR_WIDTH  counter of the frame on plaintext_data_out.
- drop_auth  out  1  one-cycle pulse: frame dropped because of auth mismatch.
- drop_replay  out  1  one-cycle pulse: frame dropped as duplicate or too old.
- accept_cnt, auth_err_cnt, replay_err_cnt  out  STAT_WIDTH each  saturating statistics.

Behaviour:
- Handshake:
  - Input transfer happens when valid_in && ready_out.
  - ready_out = !valid_out || ready_in. This is a combinational pass-through of downstream ready and is the only combinational in→out path.
- Auth check:
  - exp_tag = AUTH_SEED XOR (XOR of all FRAMER_AUTH_WIDTH slices of {payload, counter}).
  - (MSG_WIDTH+FRAMER_CNTR_WIDTH) % FRAMER_AUTH_WIDTH must be 0; elaboration error otherwise.
  - auth_ok = !CHECK_AUTH || (tag == exp_tag).
- Replay state:
  - top_cntr[CNTR-1:0], window bitmap win[WINDOW_SIZE-1:0], flag seen.
  - Bit i of win set means counter (top_cntr - i) mod 2^CNTR was already accepted.
- Replay classification of a transferred frame with counter c (all arithmetic mod 2^CNTR):
  - !seen → FRESH.
  - Otherwise compute d = c - top_cntr.
  - d != 0 and d < 2^(CNTR-1) → AHEAD.
  - Otherwise compute b = top_cntr - c.
  - b < WINDOW_SIZE and win[b] == 0 → LATE_OK.
  - All other cases → REPLAY. This includes b == 0 and b ≥ WINDOW_SIZE.
- Decision at the transfer edge:
  - !auth_ok → drop, pulse drop_auth, increment auth_err_cnt. Replay state is unchanged, and replay is not evaluated.
  - auth_ok and REPLAY → drop, pulse drop_replay, increment replay_err_cnt.
  - auth_ok and FRESH → top_cntr = c, win = 1, seen = 1, accept.
  - auth_ok and AHEAD → win = (win << d) | 1, or win = 1 if d ≥ WINDOW_SIZE; top_cntr = c; accept.
  - auth_ok and LATE_OK → win[b] = 1, accept.
- Accept action:
  - At the transfer edge, load plaintext_data_out/cntr_out and set valid_out = 1.
  - Increment accept_cnt.
  - Latency is 1 cycle from the transfer edge to valid_out.
- Output register:
  - Holds data and valid_out while valid_out && !ready_in.
  - Clears valid_out when ready_in is high and no new accept occurs in the same cycle.
  - An accept in the same cycle as a downstream take reloads the register: full throughput of 1 frame/cycle.
- Dropped frames are consumed (the input handshake completes) and produce no output.
- Back-to-back frames are classified against the state updated by the previous edge.
- Statistics counters saturate at all-ones; they never wrap.
- Pulse outputs are high for exactly the cycle after the dropping transfer edge.
- Counter wrap: top_cntr = 16'hFFFF and c = 16'h0001 gives d = 2 → AHEAD, and the window shifts by 2.
- Reset: any cycle with reset high clears all outputs to 0: valid_out, data, cntr_out, pulses and statistics. It also clears top_cntr, win and seen.
  - Reset mid-stall discards the held frame.
  - ready_out during reset = 1 (valid_out = 0). Input transfers during reset are ignored.

Test Plan:
- Reset, then frames with counters 1, 2, 3 and correct tags, ready_in = 1 → three valid_out pulses one cycle after each transfer; cntr_out = 1, 2, 3; accept_cnt = 3.
- Resend counter 2 → no valid_out; drop_replay pulses once; replay_err_cnt = 1; window unchanged, so counter 4 is still accepted.
- Frame with counter 5 and tag XOR 8'h01 → drop_auth pulse; auth_err_cnt = 1. Then counter 5 with the correct tag → accepted, which proves state was untouched.
- After top = 40, send counter 10 (b = 30, unseen) → accepted. Then counter 8 (b = 32 ≥ WINDOW_SIZE) → replay drop.
- top_cntr = 16'hFFFF, then counter 16'h0001 → accepted, top_cntr = 1. Then counter 16'hFFFF → replay drop (b = 2, bit set).
- Hold ready_in = 0 for 5 cycles with valid_in = 1 → ready_out = 0 and plaintext_data_out stable. Raise ready_in → one frame per cycle with no loss. Assert reset mid-stall → valid_out = 0 the next cycle and all stats = 0.
